reg_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing a bank of 4-bit write-enable registers between NREQ requesters.

---
 rtl/reg_write_arbiter_if.sv | 29 ++
 rtl/reg_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Requester/bank bundle for reg_write_arbiter: per-requester Req/Addr/Data/Lock in,
// one-hot grant plus the shared bank write port out.
interface reg_write_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 2
);
    localparam int unsigned DW = 4;

    logic [NREQ-1:0]    Req;
    logic [NREQ*AW-1:0] ReqAddr;
    logic [NREQ*DW-1:0] ReqData;
    logic [NREQ-1:0]    Lock;
    logic [NREQ-1:0]    Gnt;
    logic [NREG-1:0]    WE;
    logic [DW-1:0]      Data;
    logic               Err;
    logic               Busy;

    modport master (
        output Req, ReqAddr, ReqData, Lock,
        input  Gnt, WE, Data, Err, Busy
    );

    modport slave (
        input  Req, ReqAddr, ReqData, Lock,
        output Gnt, WE, Data, Err, Busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing a 4-bit register bank between NREQ requesters, one write per cycle.
// Optional burst locking is compiled in with `define ARB_LOCK_EN.
module reg_write_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    reg_write_arbiter_if.slave bus
);
    localparam int unsigned DW = 4;
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if ((2 ** AW) < NREG) begin : g_bad_aw
        $error("reg_write_arbiter: AW too narrow to address NREG registers");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1
`ifdef ARB_LOCK_EN
        ,
        ST_LOCKED = 2'd2
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREG-1:0] we_q, we_d;
    logic [DW-1:0]   data_q, data_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] elig_c;
    logic            found_c;
    logic [PW-1:0]   win_c;
    int unsigned     best_c;
    int unsigned     dist_c;
    logic            grant_c;
    logic [PW-1:0]   gidx_c;
    logic            locked_hit_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_data_c;

    function automatic logic bit_at(input logic [NREQ-1:0] v, input logic [PW-1:0] k);
        logic r;
        r = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (k == PW'(j)) r = v[j];
        end
        return r;
    endfunction

    // A requester already holding Gnt this cycle sits out this edge, so dropping Req late is safe.
    assign elig_c = bus.Req & ~gnt_q;

`ifdef ARB_LOCK_EN
    logic [PW-1:0] lw_q, lw_d;

    assign locked_hit_c = (state_q == ST_LOCKED) &&
                          bit_at(bus.Req, lw_q) && bit_at(bus.Lock, lw_q);
`else
    logic unused_lock;

    assign unused_lock  = ^bus.Lock;
    assign locked_hit_c = 1'b0;
`endif

    // Winner is the eligible requester closest to ptr going upward with wrap.
    always_comb begin : rr_search
        found_c = 1'b0;
        win_c   = '0;
        best_c  = NREQ;
        dist_c  = 0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            dist_c = (j + NREQ - 32'(ptr_q)) % NREQ;
            if (elig_c[j] && (dist_c < best_c)) begin
                found_c = 1'b1;
                best_c  = dist_c;
                win_c   = PW'(j);
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_c = 1'b0;
        gidx_c  = win_c;
`ifdef ARB_LOCK_EN
        lw_d    = lw_q;
`endif
        if (locked_hit_c) begin
`ifdef ARB_LOCK_EN
            // Locked owner keeps the bank; ptr stays frozen at owner+1.
            grant_c = 1'b1;
            gidx_c  = lw_q;
`endif
        end else if (found_c) begin
            grant_c = 1'b1;
            ptr_d   = (win_c == PW'(NREQ - 1)) ? '0 : win_c + PW'(1);
            state_d = ST_GRANT;
`ifdef ARB_LOCK_EN
            if (bit_at(bus.Lock, win_c)) begin
                state_d = ST_LOCKED;
                lw_d    = win_c;
            end
`endif
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin : out_logic
        gnt_d      = '0;
        we_d       = '0;
        data_d     = data_q;
        err_d      = 1'b0;
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (gidx_c == PW'(j)) begin
                sel_addr_c = bus.ReqAddr[j*AW +: AW];
                sel_data_c = bus.ReqData[j*DW +: DW];
            end
        end
        if (grant_c) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                gnt_d[j] = (gidx_c == PW'(j));
            end
            data_d = sel_data_c;
            // Out-of-range address still consumes the grant but never reaches the bank.
            if (32'(sel_addr_c) < NREG) begin
                for (int unsigned r = 0; r < NREG; r++) begin
                    we_d[r] = (32'(sel_addr_c) == r);
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin : state_reg
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            we_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef ARB_LOCK_EN
            lw_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef ARB_LOCK_EN
            lw_q    <= lw_d;
`endif
        end
    end

    assign bus.Gnt  = gnt_q;
    assign bus.WE   = we_q;
    assign bus.Data = data_q;
    assign bus.Err  = err_q;
    assign bus.Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed scenarios then randomized contract-following
// requesters, checked against a queue-based round-robin reference model.
module tb_reg_write_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned NREG = 3;
    localparam int unsigned AW   = 2;
    localparam int unsigned DW   = 4;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [NREG-1:0] we;
        logic [DW-1:0]   data;
        logic            err;
        logic            busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_write_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) bus ();

    reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    // Reference model state
    int          m_ptr;
    int          m_last;
    int          m_owner;
    logic [DW-1:0] m_data;

    logic [NREQ-1:0]    cur_req;
    logic [NREQ*AW-1:0] cur_addr;
    logic [NREQ*DW-1:0] cur_data;
    logic [NREQ-1:0]    cur_lock;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_last  = -1;
        m_owner = -1;
        m_data  = '0;
    endtask

    // Drive one cycle of requests and queue what the arbiter must show after the next edge.
    task automatic apply(input logic [NREQ-1:0] req, input logic [NREQ*AW-1:0] addr,
                         input logic [NREQ*DW-1:0] data, input logic [NREQ-1:0] lock);
        int   w;
        int   a;
        bit   relock;
        exp_t e;
        bus.Req     = req;
        bus.ReqAddr = addr;
        bus.ReqData = data;
        bus.Lock    = lock;
        w      = -1;
        relock = 1'b0;
`ifdef ARB_LOCK_EN
        if (m_owner >= 0 && req[m_owner] && lock[m_owner]) begin
            w      = m_owner;
            relock = 1'b1;
        end else begin
            m_owner = -1;
        end
`endif
        if (w < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (w < 0 && req[c] && c != m_last) w = c;
            end
        end
        if (w >= 0 && !relock) begin
            m_ptr = (w + 1) % NREQ;
`ifdef ARB_LOCK_EN
            if (lock[w]) m_owner = w;
`endif
        end
        e.gnt  = '0;
        e.we   = '0;
        e.err  = 1'b0;
        e.busy = 1'b0;
        if (w >= 0) begin
            a      = int'(addr[w*AW +: AW]);
            e.gnt  = NREQ'(1 << w);
            e.busy = 1'b1;
            m_data = data[w*DW +: DW];
            if (a < NREG) e.we = NREG'(1 << a);
            else          e.err = 1'b1;
        end
        e.data = m_data;
        exp_q.push_back(e);
        m_last = w;
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release on the next falling edge.
    task automatic do_reset();
        chk_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("rst_gnt",  int'(bus.Gnt),  0);
        chk("rst_we",   int'(bus.WE),   0);
        chk("rst_data", int'(bus.Data), 0);
        chk("rst_err",  int'(bus.Err),  0);
        chk("rst_busy", int'(bus.Busy), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                if (exp_q.size() == 0) begin
                    chk("expect_queue", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt",  int'(bus.Gnt),  int'(e.gnt));
                    chk("we",   int'(bus.WE),   int'(e.we));
                    chk("data", int'(bus.Data), int'(e.data));
                    chk("err",  int'(bus.Err),  int'(e.err));
                    chk("busy", int'(bus.Busy), int'(e.busy));
                end
            end
        end
    end

    initial begin : stim
        bus.Req     = '0;
        bus.ReqAddr = '0;
        bus.ReqData = '0;
        bus.Lock    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        do_reset();

        // Two requesters race for register 2: 0 first, then 1, last write holds 9
        apply(4'b0011, 8'b00_00_10_10, 16'h0095, 4'b0000);
        @(negedge clk); apply(4'b0010, 8'b00_00_10_10, 16'h0095, 4'b0000);
        @(negedge clk); apply(4'b0000, 8'b00_00_10_10, 16'h0095, 4'b0000);

        // Single write: requester 0 to register 2 with data A
        @(negedge clk); apply(4'b0001, 8'b00_00_00_10, 16'h000A, 4'b0000);
        @(negedge clk); apply(4'b0000, 8'b00_00_00_10, 16'h000A, 4'b0000);

        // Out-of-range address 3 with three registers
        @(negedge clk); apply(4'b0010, 8'b00_00_11_00, 16'h0030, 4'b0000);
        @(negedge clk); apply(4'b0000, 8'b00_00_11_00, 16'h0030, 4'b0000);

        // Reset while requester 2 is granted
        @(negedge clk); apply(4'b0100, 8'b00_01_00_00, 16'h0700, 4'b0000);
        @(posedge clk);
        #3;
        do_reset();

        // All four requesting for eight cycles: strict rotation starting at 0
        apply(4'b1111, 8'b10_01_00_10, 16'h4321, 4'b0000);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            apply(4'b1111, 8'b10_01_00_10, 16'h4321, 4'b0000);
        end

        // Randomized requesters that hold their write until granted
        cur_req  = '0;
        cur_addr = '0;
        cur_data = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!(cur_req[i] && m_last != i)) begin
                    cur_req[i]            = ($urandom_range(0, 9) < 6);
                    cur_addr[i*AW +: AW]  = AW'($urandom_range(0, 3));
                    cur_data[i*DW +: DW]  = DW'($urandom_range(0, 15));
                end
            end
            cur_lock = NREQ'($urandom_range(0, 15)) & NREQ'($urandom_range(0, 15));
            apply(cur_req, cur_addr, cur_data, cur_lock);
        end

        @(negedge clk);
        apply('0, '0, '0, '0);
        @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
